// File: rtl/mips_arb_pkg.sv
// Shared types and counter width for the MIPS unified-memory port arbiter.
package mips_arb_pkg;

  localparam int unsigned CntW = 4;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StResp
  } arb_state_t;

  typedef enum logic [1:0] {
    OwnNone,
    OwnIf,
    OwnDm
  } arb_owner_t;

endpackage

// File: rtl/mips_arb_fair_ctr.sv
// Fetch starvation counter: counts data grants given while fetch waits and
// raises force_if_o once StarveMax of them have gone by without a fetch grant.
module mips_arb_fair_ctr
  import mips_arb_pkg::*;
#(
  parameter int unsigned StarveMax = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic if_req_i,
  input  logic if_gnt_i,
  input  logic dm_gnt_i,
  output logic force_if_o
);

  localparam logic [CntW-1:0] MaxCnt = CntW'(StarveMax);

  logic [CntW-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (if_gnt_i) begin
      cnt_d = '0;
    end else if (dm_gnt_i && if_req_i && (cnt_q != MaxCnt)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign force_if_o = (cnt_q == MaxCnt);

endmodule

// File: rtl/mips_mem_port_arbiter.sv
// Shares the single-ported unified memory between fetch and data requesters.
// Build option: define MEM_ARB_FAIRNESS_EN to bound fetch starvation under data traffic.
module mips_mem_port_arbiter
  import mips_arb_pkg::*;
#(
  parameter int unsigned ADDR_W     = 10,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned MEM_LAT    = 2,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              clk1,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_kill,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_gnt,
  output logic              dm_rvalid,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  if (MEM_LAT < 1 || MEM_LAT > 15) begin : g_bad_mem_lat
    $error("MEM_LAT must be in 1..15");
  end
  if (STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_bad_starve_max
    $error("STARVE_MAX must be in 1..15");
  end

  arb_state_t        state_d, state_q;
  arb_owner_t        owner_d, owner_q;
  logic [CntW-1:0]   cnt_d, cnt_q;
  logic              kill_d, kill_q;
  logic              if_gnt_d, if_gnt_q, dm_gnt_d, dm_gnt_q;
  logic              mem_en_d, mem_en_q, mem_we_d, mem_we_q;
  logic [ADDR_W-1:0] mem_addr_d, mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_d, mem_wdata_q;
  logic              if_rvalid_d, if_rvalid_q, dm_rvalid_d, dm_rvalid_q;
  logic [DATA_W-1:0] if_rdata_d, if_rdata_q, dm_rdata_d, dm_rdata_q;
  logic              force_if;
  logic              pick_if;

`ifdef MEM_ARB_FAIRNESS_EN
  mips_arb_fair_ctr #(
    .StarveMax(STARVE_MAX)
  ) u_fair_ctr (
    .clk_i     (clk1),
    .rst_i     (reset),
    .if_req_i  (if_req),
    .if_gnt_i  (if_gnt_d),
    .dm_gnt_i  (dm_gnt_d),
    .force_if_o(force_if)
  );
`else
  assign force_if = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    cnt_d       = cnt_q;
    // A kill seen anywhere in a fetch access sticks until the next access starts.
    kill_d      = kill_q | (if_kill && (owner_q == OwnIf) && (state_q != StIdle));
    if_gnt_d    = 1'b0;
    dm_gnt_d    = 1'b0;
    mem_en_d    = 1'b0;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rvalid_d = 1'b0;
    dm_rvalid_d = 1'b0;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    pick_if     = if_req && (!dm_req || force_if);

    unique case (state_q)
      StIdle, StResp: begin
        if (if_req || dm_req) begin
          state_d  = StIssue;
          kill_d   = 1'b0;
          mem_en_d = 1'b1;
          if (pick_if) begin
            owner_d     = OwnIf;
            if_gnt_d    = 1'b1;
            mem_we_d    = 1'b0;
            mem_addr_d  = if_addr;
            mem_wdata_d = '0;
          end else begin
            owner_d     = OwnDm;
            dm_gnt_d    = 1'b1;
            mem_we_d    = dm_we;
            mem_addr_d  = dm_addr;
            mem_wdata_d = dm_wdata;
          end
        end else if (state_q == StResp) begin
          state_d = StIdle;
          owner_d = OwnNone;
          kill_d  = 1'b0;
        end
      end
      StIssue: begin
        state_d = StWait;
        cnt_d   = CntW'(MEM_LAT - 1);
      end
      StWait: begin
        if (cnt_q == '0) begin
          state_d = StResp;
          if (owner_q == OwnIf) begin
            if_rvalid_d = 1'b1;
            if_rdata_d  = mem_rdata;
          end else begin
            dm_rvalid_d = 1'b1;
            dm_rdata_d  = mem_we_q ? '0 : mem_rdata;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk1) begin
    if (reset) begin
      state_q     <= StIdle;
      owner_q     <= OwnNone;
      cnt_q       <= '0;
      kill_q      <= 1'b0;
      if_gnt_q    <= 1'b0;
      dm_gnt_q    <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rvalid_q <= 1'b0;
      dm_rvalid_q <= 1'b0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      cnt_q       <= cnt_d;
      kill_q      <= kill_d;
      if_gnt_q    <= if_gnt_d;
      dm_gnt_q    <= dm_gnt_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rvalid_q <= if_rvalid_d;
      dm_rvalid_q <= dm_rvalid_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
    end
  end

  assign if_gnt    = if_gnt_q;
  assign dm_gnt    = dm_gnt_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  // Same-cycle kill must also hide a response already on its way out.
  assign if_rvalid = if_rvalid_q & ~kill_q & ~if_kill;
  assign if_rdata  = if_rdata_q;
  assign dm_rvalid = dm_rvalid_q;
  assign dm_rdata  = dm_rdata_q;
  assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_mips_mem_port_arbiter.sv
// Randomized bench for mips_mem_port_arbiter against a transaction-level schedule model.
module tb_mips_mem_port_arbiter;

  localparam int unsigned AW = 10;
  localparam int unsigned DW = 32;
  localparam int unsigned L  = 2;
  localparam int unsigned SM = 4;

  logic          clk1     = 1'b0;
  logic          reset    = 1'b1;
  logic          if_req   = 1'b0;
  logic          if_kill  = 1'b0;
  logic          dm_req   = 1'b0;
  logic          dm_we    = 1'b0;
  logic [AW-1:0] if_addr  = '0;
  logic [AW-1:0] dm_addr  = '0;
  logic [DW-1:0] dm_wdata = '0;
  logic          if_gnt, if_rvalid, dm_gnt, dm_rvalid, mem_en, mem_we, busy;
  logic [DW-1:0] if_rdata, dm_rdata, mem_wdata, mem_rdata;
  logic [AW-1:0] mem_addr;

  always #5 clk1 = ~clk1;

  mips_mem_port_arbiter #(
    .ADDR_W    (AW),
    .DATA_W    (DW),
    .MEM_LAT   (L),
    .STARVE_MAX(SM)
  ) dut (
    .clk1     (clk1),
    .reset    (reset),
    .if_req   (if_req),
    .if_addr  (if_addr),
    .if_kill  (if_kill),
    .if_gnt   (if_gnt),
    .if_rvalid(if_rvalid),
    .if_rdata (if_rdata),
    .dm_req   (dm_req),
    .dm_we    (dm_we),
    .dm_addr  (dm_addr),
    .dm_wdata (dm_wdata),
    .dm_gnt   (dm_gnt),
    .dm_rvalid(dm_rvalid),
    .dm_rdata (dm_rdata),
    .mem_en   (mem_en),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .busy     (busy)
  );

  function automatic logic [DW-1:0] init_word(input int unsigned i);
    return (i == 5) ? 32'h2000_0001 : ((i * 32'h9E37_79B1) ^ 32'h5A5A_0F0F);
  endfunction

  // Memory environment: writes on a store strobe, read data valid L cycles after the strobe.
  logic [DW-1:0] mem [1024];
  logic [AW-1:0] rd_addr_pipe [L];
  logic          rd_v_pipe [L];
  bit            loaded = 1'b0;

  always @(posedge clk1) begin
    if (!loaded) begin
      for (int i = 0; i < 1024; i++) mem[i] = init_word(i);
      loaded = 1'b1;
    end
    if (mem_en && mem_we) mem[mem_addr] = mem_wdata;
    rd_addr_pipe[0] <= mem_addr;
    rd_v_pipe[0]    <= mem_en && !mem_we;
    for (int i = 1; i < L; i++) begin
      rd_addr_pipe[i] <= rd_addr_pipe[i-1];
      rd_v_pipe[i]    <= rd_v_pipe[i-1];
    end
  end

  assign mem_rdata = rd_v_pipe[L-1] ? mem[rd_addr_pipe[L-1]] : 32'hBADC_0FFE;

  // Reference model: one access record with the cycles it issues and responds in.
  int unsigned   n_cmp = 0, n_err = 0, cyc = 0, next_sample = 0;
  logic [DW-1:0] ref_mem [1024];
  bit            acc_v = 0, acc_if = 0, acc_kill = 0, acc_we = 0;
  int unsigned   acc_iss = 0, acc_resp = 0;
  logic [AW-1:0] acc_addr = '0;
  logic [DW-1:0] acc_wdata = '0, acc_data = '0;
  logic [DW-1:0] e_if_rdata = '0, e_dm_rdata = '0;
`ifdef MEM_ARB_FAIRNESS_EN
  int unsigned   starve = 0;
`endif
  bit            if_pend = 0, dm_pend = 0, dm_we_r = 0, rst_next = 0, kill_next = 0, prev_rst = 1;
  logic [AW-1:0] if_a = '0, dm_a = '0;
  logic [DW-1:0] dm_d = '0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  task automatic post_if(input logic [AW-1:0] a);
    if_pend = 1'b1;
    if_a    = a;
  endtask

  task automatic post_dm(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    dm_pend = 1'b1;
    dm_we_r = we;
    dm_a    = a;
    dm_d    = d;
  endtask

  task automatic step();
    bit take_if;
    bit act;
    @(posedge clk1);
    #1;
    cyc++;
    reset    = rst_next;
    if_kill  = kill_next;
    rst_next = 1'b0;
    kill_next = 1'b0;
    if_req   = if_pend;
    if_addr  = if_a;
    dm_req   = dm_pend;
    dm_we    = dm_we_r;
    dm_addr  = dm_a;
    dm_wdata = dm_d;
    act = acc_v && (cyc >= acc_iss) && (cyc <= acc_resp);
    if (act && acc_if && if_kill) acc_kill = 1'b1;
    if (acc_v && cyc == acc_resp) begin
      if (acc_if) e_if_rdata = acc_data;
      else e_dm_rdata = acc_data;
    end
    @(negedge clk1);
    check_eq("busy", 32'(busy), 32'(act));
    check_eq("if_gnt", 32'(if_gnt), 32'(acc_v && acc_if && cyc == acc_iss));
    check_eq("dm_gnt", 32'(dm_gnt), 32'(acc_v && !acc_if && cyc == acc_iss));
    check_eq("mem_en", 32'(mem_en), 32'(acc_v && cyc == acc_iss));
    check_eq("if_rvalid", 32'(if_rvalid), 32'(acc_v && acc_if && !acc_kill && cyc == acc_resp));
    check_eq("dm_rvalid", 32'(dm_rvalid), 32'(acc_v && !acc_if && cyc == acc_resp));
    check_eq("if_rdata", if_rdata, e_if_rdata);
    check_eq("dm_rdata", dm_rdata, e_dm_rdata);
    if (acc_v && cyc == acc_iss) begin
      check_eq("mem_we", 32'(mem_we), 32'(acc_we));
      check_eq("mem_addr", 32'(mem_addr), 32'(acc_addr));
      check_eq("mem_wdata", mem_wdata, acc_wdata);
    end
    if (prev_rst) begin
      check_eq("rst_mem_we", 32'(mem_we), 32'd0);
      check_eq("rst_mem_addr", 32'(mem_addr), 32'd0);
      check_eq("rst_mem_wdata", mem_wdata, 32'd0);
    end
    prev_rst = reset;
    if (reset) begin
      acc_v       = 1'b0;
      e_if_rdata  = '0;
      e_dm_rdata  = '0;
      next_sample = cyc + 1;
`ifdef MEM_ARB_FAIRNESS_EN
      starve = 0;
`endif
    end else if (cyc >= next_sample && (if_pend || dm_pend)) begin
`ifdef MEM_ARB_FAIRNESS_EN
      take_if = if_pend && (!dm_pend || starve == SM);
      if (take_if) starve = 0;
      else if (if_pend) starve++;
`else
      take_if = if_pend && !dm_pend;
`endif
      acc_v    = 1'b1;
      acc_if   = take_if;
      acc_kill = 1'b0;
      acc_iss  = cyc + 1;
      acc_resp = cyc + 2 + L;
      if (take_if) begin
        acc_we    = 1'b0;
        acc_addr  = if_a;
        acc_wdata = '0;
        acc_data  = ref_mem[if_a];
        if_pend   = 1'b0;
      end else begin
        acc_we    = dm_we_r;
        acc_addr  = dm_a;
        acc_wdata = dm_d;
        if (dm_we_r) begin
          ref_mem[dm_a] = dm_d;
          acc_data      = '0;
        end else begin
          acc_data = ref_mem[dm_a];
        end
        dm_pend = 1'b0;
      end
      next_sample = acc_resp;
    end
  endtask

  int unsigned n_obs, gi, ndiff;
  logic [5:0]  seq;

  initial begin
    for (int i = 0; i < 1024; i++) ref_mem[i] = init_word(i);
    repeat (2) @(posedge clk1);
    repeat (3) step();

    // Lone fetch of word 5.
    post_if(10'd5);
    repeat (6) step();

    // Fetch and store together: store first.
    post_if(10'd3);
    post_dm(1'b1, 10'd9, 32'hDEAD_BEEF);
    repeat (12) step();
    check_eq("word9", mem[9], 32'hDEAD_BEEF);

    // Kill in the WAIT cycle of a fetch, then a normal load.
    post_if(10'd7);
    step();
    step();
    kill_next = 1'b1;
    n_obs = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (if_rvalid) n_obs++;
    end
    check_eq("killed_if_rvalid_cnt", n_obs, 0);
    post_dm(1'b0, 10'd5, 32'h0);
    repeat (6) step();

    // Reset during WAIT of a load.
    post_dm(1'b0, 10'd9, 32'h0);
    repeat (3) step();
    rst_next = 1'b1;
    step();
    n_obs = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (dm_rvalid || if_rvalid) n_obs++;
    end
    check_eq("abandoned_rvalid_cnt", n_obs, 0);
    post_if(10'd2);
    repeat (6) step();

    // Both ports requesting continuously from a fresh reset.
    rst_next = 1'b1;
    step();
    gi  = 0;
    seq = '0;
    for (int i = 0; i < 80 && gi < 6; i++) begin
      if (!if_pend) post_if(AW'($urandom_range(0, 31)));
      if (!dm_pend) post_dm(1'($urandom_range(0, 1)), AW'($urandom_range(0, 31)), $urandom);
      step();
      if (if_gnt || dm_gnt) begin
        seq[gi] = if_gnt;
        gi++;
      end
    end
    check_eq("grant_count", gi, 6);
`ifdef MEM_ARB_FAIRNESS_EN
    check_eq("grant_seq", 32'(seq), 32'h10);
`else
    check_eq("grant_seq", 32'(seq), 32'h0);
`endif
    repeat (14) step();

    // Random traffic with kills and occasional resets.
    for (int n = 0; n < 600; n++) begin
      if (!if_pend && $urandom_range(0, 3) == 0) post_if(AW'($urandom_range(0, 31)));
      if (!dm_pend && $urandom_range(0, 3) == 0)
        post_dm(1'($urandom_range(0, 1)), AW'($urandom_range(0, 31)), $urandom);
      kill_next = ($urandom_range(0, 9) == 0);
      rst_next  = ($urandom_range(0, 149) == 0);
      step();
    end
    repeat (16) step();

    ndiff = 0;
    for (int i = 0; i < 1024; i++) if (mem[i] !== ref_mem[i]) ndiff++;
    check_eq("mem_image_diffs", ndiff, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
